game_flow_ctrl: RTL and testbench

Frame-level game-flow controller between the keyboard decoder / Q-learning agent and the bird, pipe, background and score stages. Converts key presses (or the agent's request) into exactly-one-frame jump strobes. Freezes input after a collision and holds a death animation window. Issues a one-frame game restart and keeps the session best score for the pixel generator.

---
 rtl/game_flow_ctrl.sv | 124 ++++++++++++
 tb/tb_game_flow_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/game_flow_ctrl.sv
// Frame-level game-flow FSM: jump strobes, death window, restart pulse, session best score.
// Optional auto-restart from OVER is enabled by defining GAME_FLOW_AUTORESTART_EN.
module game_flow_ctrl #(
    parameter int DEATH_FRAMES   = 30,
    parameter int RESTART_FRAMES = 60,
    parameter int SCORE_W        = 7
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               fps_tick,
    input  logic               key_jump,
    input  logic               ai_mode,
    input  logic               ai_jump,
    input  logic               is_collide,
    input  logic [SCORE_W-1:0] current_score,
    output logic               jump,
    output logic               game_rst,
    output logic [1:0]         state,
    output logic [SCORE_W-1:0] best_score
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PLAY  = 2'd1,
        DYING = 2'd2,
        OVER  = 2'd3
    } state_t;

    localparam logic [7:0] DEATH_LOAD   = 8'(DEATH_FRAMES - 1);
    // The timer is reloaded on OVER entry in every build; only auto-restart reads it there.
    localparam logic [7:0] RESTART_LOAD = 8'(RESTART_FRAMES - 1);

    state_t             cur, nxt;
    logic               key_prev, pending, pending_nxt;
    logic               press, want;
    logic [7:0]         timer, timer_nxt;
    logic               jump_nxt, game_rst_nxt;
    logic [SCORE_W-1:0] best_nxt;

    assign press = key_jump & ~key_prev;
    // A press landing in the tick cycle itself still counts for that frame.
    assign want  = pending | press;
    assign state = cur;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur        <= IDLE;
            key_prev   <= 1'b0;
            pending    <= 1'b0;
            timer      <= 8'd0;
            jump       <= 1'b0;
            game_rst   <= 1'b0;
            best_score <= '0;
        end else begin
            cur        <= nxt;
            key_prev   <= key_jump;
            pending    <= pending_nxt;
            timer      <= timer_nxt;
            jump       <= jump_nxt;
            game_rst   <= game_rst_nxt;
            best_score <= best_nxt;
        end
    end

    always_comb begin
        nxt          = cur;
        timer_nxt    = timer;
        jump_nxt     = jump;
        game_rst_nxt = game_rst;
        best_nxt     = best_score;
        pending_nxt  = pending | (press & (cur != DYING));

        if (fps_tick) begin
            pending_nxt  = 1'b0;
            jump_nxt     = 1'b0;
            game_rst_nxt = 1'b0;
            case (cur)
                IDLE: begin
                    if (want | (ai_mode & ai_jump)) begin
                        nxt      = PLAY;
                        jump_nxt = 1'b1;
                    end
                end
                PLAY: begin
                    // Collision wins over any jump request in the same frame.
                    if (is_collide) begin
                        nxt       = DYING;
                        timer_nxt = DEATH_LOAD;
                        if (current_score > best_score) begin
                            best_nxt = current_score;
                        end
                    end else begin
                        jump_nxt = ai_mode ? ai_jump : want;
                    end
                end
                DYING: begin
                    if (timer == 8'd0) begin
                        nxt       = OVER;
                        timer_nxt = RESTART_LOAD;
                    end else begin
                        timer_nxt = timer - 8'd1;
                    end
                end
                OVER: begin
`ifdef GAME_FLOW_AUTORESTART_EN
                    if (want | ai_mode | (timer == 8'd0)) begin
                        nxt          = IDLE;
                        game_rst_nxt = 1'b1;
                    end else begin
                        timer_nxt = timer - 8'd1;
                    end
`else
                    if (want) begin
                        nxt          = IDLE;
                        game_rst_nxt = 1'b1;
                    end
`endif
                end
                default: nxt = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Scoreboard bench for game_flow_ctrl: frame-level reference model feeds an expected queue,
// a monitor compares the DUT outputs after every frame tick.
module tb_game_flow_ctrl;

    localparam int DEATH   = 30;
    localparam int RESTART = 4;
    localparam int SW      = 7;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          fps_tick = 1'b0;
    logic          key_jump = 1'b0;
    logic          ai_mode = 1'b0;
    logic          ai_jump = 1'b0;
    logic          is_collide = 1'b0;
    logic [SW-1:0] current_score = '0;
    logic          jump, game_rst;
    logic [1:0]    state;
    logic [SW-1:0] best_score;

    int checks = 0;
    int errors = 0;
    logic [SW+3:0] exp_q[$];

    // reference model state (frame-level view)
    int   m_ph = 0;     // 0 idle, 1 play, 2 dying, 3 over
    int   m_cnt = 0;    // frames still to spend in the current timed phase
    int   m_best = 0;
    logic m_pend = 1'b0, m_kprev = 1'b0, m_j = 1'b0, m_g = 1'b0;

    game_flow_ctrl #(
        .DEATH_FRAMES(DEATH), .RESTART_FRAMES(RESTART), .SCORE_W(SW)
    ) dut (
        .clk(clk), .rst(rst), .fps_tick(fps_tick), .key_jump(key_jump),
        .ai_mode(ai_mode), .ai_jump(ai_jump), .is_collide(is_collide),
        .current_score(current_score), .jump(jump), .game_rst(game_rst),
        .state(state), .best_score(best_score)
    );

    always #5 clk = ~clk;

    // reference model: evaluated on every rising edge from the documented frame rules
    initial begin
        logic press, want, restart;
        forever begin
            @(posedge clk);
            if (!rst) begin
                m_ph = 0; m_cnt = 0; m_best = 0;
                m_pend = 0; m_kprev = 0; m_j = 0; m_g = 0;
            end else begin
                press   = key_jump && !m_kprev;
                m_kprev = key_jump;
                if (fps_tick) begin
                    want = m_pend || press;
                    m_g  = 0;
                    m_j  = 0;
                    case (m_ph)
                        0: if (want || (ai_mode && ai_jump)) begin m_ph = 1; m_j = 1; end
                        1: begin
                            if (is_collide) begin
                                m_ph = 2; m_cnt = DEATH;
                                if (int'(current_score) > m_best) m_best = int'(current_score);
                            end else begin
                                m_j = ai_mode ? ai_jump : want;
                            end
                        end
                        2: begin
                            m_cnt = m_cnt - 1;
                            if (m_cnt == 0) begin m_ph = 3; m_cnt = RESTART; end
                        end
                        default: begin
                            restart = want;
`ifdef GAME_FLOW_AUTORESTART_EN
                            m_cnt = m_cnt - 1;
                            if (m_cnt == 0 || ai_mode) restart = 1;
`endif
                            if (restart) begin m_g = 1; m_ph = 0; end
                        end
                    endcase
                    m_pend = 0;
                    exp_q.push_back({2'(m_ph), m_j, m_g, SW'(m_best)});
                end else if (press && m_ph != 2) begin
                    m_pend = 1;
                end
            end
        end
    end

    // monitor: outputs are only defined to move on a tick edge
    initial begin
        logic t;
        logic [SW+3:0] e, got;
        forever begin
            @(posedge clk);
            t = fps_tick && rst;
            #1;
            if (t) begin
                got = {state, jump, game_rst, best_score};
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL frame_out: no expected entry, got state=%0d jump=%0b game_rst=%0b best=%0d",
                             state, jump, game_rst, best_score);
                end else begin
                    e = exp_q.pop_front();
                    if (got !== e) begin
                        errors++;
                        $display("FAIL frame_out t=%0t: got state=%0d jump=%0b game_rst=%0b best=%0d, want state=%0d jump=%0b game_rst=%0b best=%0d",
                                 $time, got[SW+3:SW+2], got[SW+1], got[SW], got[SW-1:0],
                                 e[SW+3:SW+2], e[SW+1], e[SW], e[SW-1:0]);
                    end
                end
            end
        end
    end

    task automatic cyc(input logic t);
        @(negedge clk);
        fps_tick = t;
    endtask

    task automatic frames(input int n);
        repeat (n) begin cyc(0); cyc(1); end
    endtask

    // key rises 'lead' cycles before the tick (0 = in the tick cycle itself)
    task automatic press_tick(input int lead);
        cyc(0); key_jump = 0;
        cyc(0);
        if (lead == 0) begin
            cyc(1); key_jump = 1;
        end else begin
            key_jump = 1;
            repeat (lead - 1) cyc(0);
            cyc(1);
        end
    endtask

    task automatic check_zero(input string name);
        checks++;
        if ({state, jump, game_rst, best_score} !== '0) begin
            errors++;
            $display("FAIL %s: got state=%0d jump=%0b game_rst=%0b best=%0d, want all 0",
                     name, state, jump, game_rst, best_score);
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check_zero("reset_state");
        rst = 1;

        frames(5);                          // idle, no input
        press_tick(3);                      // start with a keyboard press
        frames(10);                         // key held: no further jumps

        current_score = 12; is_collide = 1;
        press_tick(0);                      // collision beats same-tick press
        cyc(0); is_collide = 0;
        for (int i = 0; i < DEATH; i++) begin
            cyc(0); key_jump = ~key_jump;   // presses during DYING are ignored
            cyc(1);
        end
        key_jump = 0;
        frames(2);
        press_tick(2);                      // restart from OVER
        frames(3);                          // key held: no start
        press_tick(1);                      // new game

        ai_mode = 1; ai_jump = 1;
        frames(3);
        ai_jump = 0;
        frames(1);
        cyc(0); ai_mode = 0; ai_jump = 1;   // switch to keyboard mid-frame
        press_tick(1);
        frames(1);

        current_score = 9; is_collide = 1; ai_jump = 0;
        frames(1);
        is_collide = 0; key_jump = 0;
        frames(DEATH + 5);                  // OVER; auto-restart when enabled
        press_tick(1);

        for (int f = 0; f < 400; f++) begin
            int gap;
            gap = $urandom_range(1, 4);
            for (int c = 0; c < gap; c++) begin
                cyc(0);
                if ($urandom_range(0, 2) == 0) key_jump = ~key_jump;
            end
            if ($urandom_range(0, 7) == 0) ai_mode = ~ai_mode;
            ai_jump       = 1'($urandom_range(0, 1));
            is_collide    = ($urandom_range(0, 5) == 0);
            current_score = SW'($urandom_range(0, 127));
            cyc(1);
        end

        // drive into DYING, then pull reset between clock edges
        ai_mode = 1; ai_jump = 1; is_collide = 1;
        for (int k = 0; k < 200 && m_ph != 2; k++) press_tick(1);
        is_collide = 0;
        checks++;
        if (m_ph != 2) begin
            errors++;
            $display("FAIL reach_dying: model phase=%0d, want 2", m_ph);
        end
        cyc(0);
        #2 rst = 0;
        #1 check_zero("async_reset_in_dying");
        exp_q.delete();
        @(negedge clk); rst = 1;
        ai_mode = 0; ai_jump = 0; key_jump = 0;
        frames(3);

        repeat (2) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL queue_drain: %0d entries left, want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
